// File: rtl/pl_dmem_pkg.sv
// rtl/pl_dmem_pkg.sv - shared encodings and helpers for the MEM-stage data memory
// Contents: access-size codes, controller state codes, byte-lane mask helper.
package pl_dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam logic ST_CLEAR = 1'b0;
  localparam logic ST_READY = 1'b1;

  // Byte lanes touched by an access of size sz at byte offset off (little-endian).
  function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: lane_mask = 4'b0001 << off;
      SZ_HALF: lane_mask = off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/pl_dmem_array.sv
// rtl/pl_dmem_array.sv - DEPTH_WORDS x 32 synchronous RAM with byte write enables
// Ports:
//   clock, reset        rising-edge clock, sync active-high reset (read register only)
//   idx_i               word index shared by read and write
//   be_i, wdata_i       per-lane write enables and lane-replicated write data
//   re_i                read enable; rdata_o holds its value when re_i is low
//   rdata_o             registered read data
module pl_dmem_array
  import pl_dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 32,
  parameter int AW          = 5
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] idx_i,
  input  logic [3:0]    be_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clock) begin
    for (int l = 0; l < 4; l++) begin
      if (be_i[l]) begin
        mem[idx_i][8*l +: 8] <= wdata_i[8*l +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pl_dmem_ctrl.sv
// rtl/pl_dmem_ctrl.sv - MEM-stage data memory controller (sub-word access, power-on clear)
// Ports:
//   clock, reset        rising-edge clock, sync active-high reset
//   addr, datain        byte address and right-aligned store data
//   we, re, size, sext  store/load request, access size, load sign-extension
//   dataout, dvalid     load result and its one-cycle valid pulse
//   misalign            one-cycle pulse: the previous request was rejected
//   ready               requests are accepted
module pl_dmem_ctrl
  import pl_dmem_pkg::*;
#(
  parameter int DEPTH_WORDS    = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] datain,
  input  logic        we,
  input  logic        re,
  input  logic [1:0]  size,
  input  logic        sext,
  output logic [31:0] dataout,
  output logic        dvalid,
  output logic        misalign,
  output logic        ready
);

  localparam int            AW       = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

  logic          state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          ready_q, dvalid_q, misalign_q;
  logic [1:0]    off_q, size_q;
  logic          sext_q;

  logic          clearing, misal, accept, wr_go, rd_go;
  logic [AW-1:0] word_idx, arr_idx;
  logic [3:0]    arr_be;
  logic [31:0]   wdata_rep, arr_wdata, rdata;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic          unused_addr_bits;

  // Upper address bits alias onto the array.
  assign word_idx         = addr[AW+1:2];
  assign unused_addr_bits = ^addr[31:AW+2];

  assign clearing = (state_q == ST_CLEAR);
  assign misal    = (size == SZ_ILL) ||
                    ((size == SZ_HALF) && addr[0]) ||
                    ((size == SZ_WORD) && (addr[1:0] != 2'b00));
  assign accept   = ready_q && (we || re);
  // A store wins over a simultaneous load.
  assign wr_go    = accept && !misal && we;
  assign rd_go    = accept && !misal && re && !we;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + AW'(1);
      if (cnt_q == LAST_IDX) begin
        state_d = ST_READY;
      end
    end
  end

  // Replicating the right-aligned data onto every lane lets the lane mask pick the target bytes.
  always_comb begin
    case (size)
      SZ_BYTE: wdata_rep = {4{datain[7:0]}};
      SZ_HALF: wdata_rep = {2{datain[15:0]}};
      default: wdata_rep = datain;
    endcase
  end

  assign arr_idx   = clearing ? cnt_q : word_idx;
  assign arr_be    = clearing ? 4'b1111 : (wr_go ? lane_mask(size, addr[1:0]) : 4'b0000);
  assign arr_wdata = clearing ? 32'h0 : wdata_rep;

  pl_dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clock  (clock),
    .reset  (reset),
    .idx_i  (arr_idx),
    .be_i   (arr_be),
    .wdata_i(arr_wdata),
    .re_i   (rd_go),
    .rdata_o(rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      dvalid_q   <= 1'b0;
      misalign_q <= 1'b0;
      off_q      <= 2'b00;
      size_q     <= SZ_BYTE;
      sext_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      // ready lags the state by one edge so the last cleared word is written before any request.
      ready_q    <= (state_q == ST_READY);
      dvalid_q   <= rd_go;
      misalign_q <= accept && misal;
      // Extraction controls only change with a new load, so dataout holds between loads.
      if (rd_go) begin
        off_q  <= addr[1:0];
        size_q <= size;
        sext_q <= sext;
      end
    end
  end

  assign ld_byte = rdata[{off_q, 3'b000} +: 8];
  assign ld_half = off_q[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    case (size_q)
      SZ_BYTE: dataout = {{24{sext_q & ld_byte[7]}}, ld_byte};
      SZ_HALF: dataout = {{16{sext_q & ld_half[15]}}, ld_half};
      default: dataout = rdata;
    endcase
  end

  assign dvalid   = dvalid_q;
  assign misalign = misalign_q;
  assign ready    = ready_q;

endmodule

// File: tb/tb_pl_dmem_ctrl.sv
// tb/tb_pl_dmem_ctrl.sv - randomized self-checking bench for pl_dmem_ctrl
module tb_pl_dmem_ctrl;

  localparam int DEPTH = 32;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] datain = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sext = 1'b0;
  logic [31:0] dataout;
  logic        dvalid;
  logic        misalign;
  logic        ready;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] last_dout = '0;

  pl_dmem_ctrl #(
    .DEPTH_WORDS   (DEPTH),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .addr    (addr),
    .datain  (datain),
    .we      (we),
    .re      (re),
    .size    (size),
    .sext    (sext),
    .dataout (dataout),
    .dvalid  (dvalid),
    .misalign(misalign),
    .ready   (ready)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  task automatic rand_req();
    we     = 1'($urandom_range(0, 1));
    re     = 1'($urandom_range(0, 1));
    size   = 2'($urandom_range(0, 3));
    sext   = 1'($urandom_range(0, 1));
    addr   = $urandom;
    datain = $urandom;
  endtask

  // One request cycle; expectations come from the byte-level memory model.
  task automatic op(input string tag, input logic w, input logic r, input logic [1:0] sz,
                    input logic sx, input logic [31:0] a, input logic [31:0] d);
    int          idx, off, nbytes;
    logic        mis, ld;
    logic [31:0] m, v;
    we = w; re = r; size = sz; sext = sx; addr = a; datain = d;
    @(posedge clock);
    #1;
    we = 1'b0; re = 1'b0;
    idx    = int'((a / 4) % DEPTH);
    off    = int'(a % 4);
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    m      = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
    mis    = (w || r) && ((sz == 2'd3) || (sz == 2'd1 && off % 2 != 0) || (sz == 2'd2 && off != 0));
    ld     = r && !w && !mis;
    if (w && !mis) begin
      model[idx] = (model[idx] & ~(m << (8 * off))) | ((d & m) << (8 * off));
    end
    if (ld) begin
      v = (model[idx] >> (8 * off)) & m;
      if (sx && nbytes < 4 && v > (m >> 1)) v = v - (m + 32'd1);
      last_dout = v;
    end
    check({tag, ".dvalid"}, 32'(dvalid), 32'(ld));
    check({tag, ".misalign"}, 32'(misalign), 32'(mis));
    check({tag, ".dataout"}, dataout, last_dout);
    check({tag, ".ready"}, 32'(ready), 32'd1);
  endtask

  initial begin
    int cnt;
    int kind;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;

    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst.dataout", dataout, 32'h0);
    check("rst.dvalid", 32'(dvalid), 32'd0);
    check("rst.misalign", 32'(misalign), 32'd0);
    check("rst.ready", 32'(ready), 32'd0);

    // Partial clear with traffic, then reset again mid-clear.
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      rand_req();
      @(posedge clock);
      #1;
      check("clr1.dvalid", 32'(dvalid), 32'd0);
      check("clr1.misalign", 32'(misalign), 32'd0);
      check("clr1.ready", 32'(ready), 32'd0);
    end
    we = 1'b0; re = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("rst2.ready", 32'(ready), 32'd0);
    reset = 1'b0;
    cnt = 0;
    while (cnt < 200) begin
      rand_req();
      @(posedge clock);
      #1;
      cnt++;
      check("clr2.dvalid", 32'(dvalid), 32'd0);
      check("clr2.misalign", 32'(misalign), 32'd0);
      if (ready) break;
    end
    we = 1'b0; re = 1'b0;
    check("ready_latency", 32'(cnt), 32'(DEPTH + 1));

    for (int a = 0; a < 4 * DEPTH; a += 4) begin
      op("zero", 1'b0, 1'b1, 2'd2, 1'b0, 32'(a), 32'h0);
      check("zero.lit", dataout, 32'h0);
    end

    op("sw10", 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h80FF7F01);
    op("lb11", 1'b0, 1'b1, 2'd0, 1'b1, 32'h11, 32'h0);
    check("lb11.lit", dataout, 32'h0000007F);
    op("lb12", 1'b0, 1'b1, 2'd0, 1'b1, 32'h12, 32'h0);
    check("lb12.lit", dataout, 32'hFFFFFFFF);
    op("lbu13", 1'b0, 1'b1, 2'd0, 1'b0, 32'h13, 32'h0);
    check("lbu13.lit", dataout, 32'h00000080);
    op("lh12", 1'b0, 1'b1, 2'd1, 1'b1, 32'h12, 32'h0);
    check("lh12.lit", dataout, 32'hFFFF80FF);

    op("sw20", 1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h11223344);
    op("sb21", 1'b1, 1'b0, 2'd0, 1'b0, 32'h21, 32'h000000AA);
    op("lw20a", 1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h0);
    check("lw20a.lit", dataout, 32'h1122AA44);
    op("sh22", 1'b1, 1'b0, 2'd1, 1'b0, 32'h22, 32'h0000BEEF);
    op("lw20b", 1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h0);
    check("lw20b.lit", dataout, 32'hBEEFAA44);

    op("mis_lw06", 1'b0, 1'b1, 2'd2, 1'b0, 32'h06, 32'h0);
    op("mis_sh05", 1'b1, 1'b0, 2'd1, 1'b0, 32'h05, 32'h0000FFFF);
    op("mis_sz3", 1'b1, 1'b0, 2'd3, 1'b0, 32'h00, 32'hFFFFFFFF);
    op("post_mis04", 1'b0, 1'b1, 2'd2, 1'b0, 32'h04, 32'h0);
    op("post_mis00", 1'b0, 1'b1, 2'd2, 1'b0, 32'h00, 32'h0);
    check("post_mis00.lit", dataout, 32'h0);

    op("sw04", 1'b1, 1'b0, 2'd2, 1'b0, 32'h04, 32'hDEADBEEF);
    op("lw84", 1'b0, 1'b1, 2'd2, 1'b0, 32'h84, 32'h0);
    check("lw84.lit", dataout, 32'hDEADBEEF);
    op("we_re", 1'b1, 1'b1, 2'd2, 1'b0, 32'h08, 32'h12345678);
    op("lw08", 1'b0, 1'b1, 2'd2, 1'b0, 32'h08, 32'h0);
    check("lw08.lit", dataout, 32'h12345678);

    for (int n = 0; n < 400; n++) begin
      kind = int'($urandom_range(0, 7));
      op("rnd", (kind <= 2) || (kind == 6), (kind >= 3 && kind <= 6),
         2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1);
  end

endmodule
